// File: rtl/bidir_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// bidir_bus_ctrl_if : request/write/read-back and pad signals of bidir_bus_ctrl
// Revision: 1.0
// ============================================================================
interface bidir_bus_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             dir_req;
   logic [WIDTH-1:0] wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [WIDTH-1:0] pad_out;
   logic             pad_oe;
   logic [WIDTH-1:0] pad_in;
   logic [1:0]       state;

   modport master (
      output dir_req, wr_data, wr_valid, pad_in,
      input  wr_ready, rd_data, rd_valid, pad_out, pad_oe, state
   );

   modport slave (
      input  dir_req, wr_data, wr_valid, pad_in,
      output wr_ready, rd_data, rd_valid, pad_out, pad_oe, state
   );
endinterface
`default_nettype wire

// File: rtl/bidir_bus_ctrl.sv
`default_nettype none
// ============================================================================
// bidir_bus_ctrl : shared-bus driver with Hi-Z turnaround and synchronised read-back
// Revision: 1.0
// ============================================================================
module bidir_bus_ctrl #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic       clk,
   input  wire logic       reset,
   bidir_bus_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      TURN_OUT = 2'd1,
      DRIVING  = 2'd2,
      TURN_IN  = 2'd3
   } state_t;

   localparam int              TW        = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
   localparam logic [TW-1:0]   TURN_LAST = TW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
   localparam int              RW        = $clog2(SYNC_STAGES + 1);
   localparam logic [RW-1:0]   REL_FULL  = RW'(SYNC_STAGES);
   // With no dead cycles the FSM hops straight between RELEASED and DRIVING.
   localparam state_t          OUT_ENTRY = (TURN_CYCLES > 0) ? TURN_OUT : DRIVING;
   localparam state_t          IN_ENTRY  = (TURN_CYCLES > 0) ? TURN_IN  : RELEASED;

   state_t           st;
   logic [TW-1:0]    turn_cnt;
   logic             oe_q;
   logic [WIDTH-1:0] out_q;
   logic [RW-1:0]    rel_cnt;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic             write_ok;

   assign write_ok = (st == DRIVING) & bus.dir_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= RELEASED;
         oe_q     <= 1'b0;
         out_q    <= '0;
         turn_cnt <= '0;
         rel_cnt  <= '0;
      end else begin
         case (st)
            RELEASED: begin
               if (bus.dir_req) begin
                  st       <= OUT_ENTRY;
                  oe_q     <= (OUT_ENTRY == DRIVING);
                  turn_cnt <= '0;
               end
            end
            TURN_OUT: begin
               if (turn_cnt == TURN_LAST) begin
                  st   <= DRIVING;
                  oe_q <= 1'b1;
               end else begin
                  turn_cnt <= turn_cnt + 1'b1;
               end
            end
            DRIVING: begin
               if (!bus.dir_req) begin
                  st       <= IN_ENTRY;
                  oe_q     <= 1'b0;
                  turn_cnt <= '0;
               end
            end
            TURN_IN: begin
               if (turn_cnt == TURN_LAST) begin
                  st <= RELEASED;
               end else begin
                  turn_cnt <= turn_cnt + 1'b1;
               end
            end
         endcase

         if (write_ok && bus.wr_valid) begin
            out_q <= bus.wr_data;
         end

         // Read-back is trusted only once the whole sync chain holds released-bus samples.
         if (st == RELEASED) begin
            if (rel_cnt != REL_FULL) begin
               rel_cnt <= rel_cnt + 1'b1;
            end
         end else begin
            rel_cnt <= '0;
         end
      end
   end

   generate
      for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync_stage
         always_ff @(posedge clk) begin
            if (reset) begin
               sync_q[i] <= '0;
            end else if (i == 0) begin
               sync_q[i] <= bus.pad_in;
            end else begin
               sync_q[i] <= sync_q[(i > 0) ? i - 1 : 0];
            end
         end
      end
   endgenerate

   assign bus.state    = st;
   assign bus.pad_oe   = oe_q;
   assign bus.pad_out  = out_q;
   assign bus.wr_ready = write_ok;
   assign bus.rd_data  = sync_q[SYNC_STAGES-1];
   assign bus.rd_valid = (st == RELEASED) & (rel_cnt == REL_FULL);
endmodule
`default_nettype wire

// File: tb/tb_bidir_bus_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bidir_bus_ctrl : scoreboard bench, TURN_CYCLES=2 instance then TURN_CYCLES=0
// Revision: 1.0
// ============================================================================
module tb_bidir_bus_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   bidir_bus_ctrl_if #(.WIDTH(8)) bus_a ();
   bidir_bus_ctrl_if #(.WIDTH(8)) bus_b ();

   bidir_bus_ctrl #(.WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(2)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a.slave)
   );

   bidir_bus_ctrl #(.WIDTH(8), .TURN_CYCLES(0), .SYNC_STAGES(2)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b.slave)
   );

   typedef struct {
      int         row;
      bit         sel;
      logic [1:0] st;
      logic       oe;
      logic [7:0] out;
      logic       rdy;
      logic       rv;
      bit         chk_rd;
      logic [7:0] rd;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   row_no = 0;

   task automatic chk(input string name, input int row, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, got, exp);
      end
   endtask

   // Inputs change on the falling edge; expectations describe outputs after the next rising edge.
   task automatic step(input bit sel, input bit rst, input bit dir, input bit wv,
                       input logic [7:0] wd, input logic [7:0] pin,
                       input logic [1:0] st, input logic oe, input logic [7:0] out,
                       input logic rdy, input logic rv, input bit crd, input logic [7:0] rd);
      exp_t e;
      @(negedge clk);
      rst_a = sel ? 1'b1 : rst;
      rst_b = sel ? rst : 1'b1;
      bus_a.dir_req  = sel ? 1'b0 : dir;
      bus_a.wr_valid = sel ? 1'b0 : wv;
      bus_a.wr_data  = sel ? 8'h00 : wd;
      bus_a.pad_in   = sel ? 8'h00 : pin;
      bus_b.dir_req  = sel ? dir : 1'b0;
      bus_b.wr_valid = sel ? wv : 1'b0;
      bus_b.wr_data  = sel ? wd : 8'h00;
      bus_b.pad_in   = sel ? pin : 8'h00;
      e.row = row_no; e.sel = sel; e.st = st; e.oe = oe; e.out = out;
      e.rdy = rdy; e.rv = rv; e.chk_rd = crd; e.rd = rd;
      q.push_back(e);
      row_no++;
   endtask

   initial begin : monitor
      exp_t e;
      logic [1:0] g_st;
      logic       g_oe, g_rdy, g_rv;
      logic [7:0] g_out, g_rd;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            g_st  = e.sel ? bus_b.state    : bus_a.state;
            g_oe  = e.sel ? bus_b.pad_oe   : bus_a.pad_oe;
            g_out = e.sel ? bus_b.pad_out  : bus_a.pad_out;
            g_rdy = e.sel ? bus_b.wr_ready : bus_a.wr_ready;
            g_rv  = e.sel ? bus_b.rd_valid : bus_a.rd_valid;
            g_rd  = e.sel ? bus_b.rd_data  : bus_a.rd_data;
            chk("state",    e.row, {6'b0, g_st},  {6'b0, e.st});
            chk("pad_oe",   e.row, {7'b0, g_oe},  {7'b0, e.oe});
            chk("pad_out",  e.row, g_out,         e.out);
            chk("wr_ready", e.row, {7'b0, g_rdy}, {7'b0, e.rdy});
            chk("rd_valid", e.row, {7'b0, g_rv},  {7'b0, e.rv});
            if (e.chk_rd) chk("rd_data", e.row, g_rd, e.rd);
            chk("oe_only_driving_a", e.row, {7'b0, bus_a.pad_oe & (bus_a.state != 2'd2)}, 8'h00);
            chk("oe_only_driving_b", e.row, {7'b0, bus_b.pad_oe & (bus_b.state != 2'd2)}, 8'h00);
         end
      end
   end

   initial begin : driver
      bus_a.dir_req = 1'b0; bus_a.wr_valid = 1'b0; bus_a.wr_data = 8'h00; bus_a.pad_in = 8'h00;
      bus_b.dir_req = 1'b0; bus_b.wr_valid = 1'b0; bus_b.wr_data = 8'h00; bus_b.pad_in = 8'h00;

      // TURN_CYCLES=2: reset, idle read-back
      step(0,1,0,0,8'h00,8'hA5, 2'd0,0,8'h00,0,0,1,8'h00);
      step(0,1,0,0,8'h00,8'hA5, 2'd0,0,8'h00,0,0,1,8'h00);
      step(0,0,0,0,8'h00,8'hA5, 2'd0,0,8'h00,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'hA5, 2'd0,0,8'h00,0,1,1,8'hA5);
      step(0,0,0,0,8'h00,8'hA5, 2'd0,0,8'h00,0,1,1,8'hA5);
      // acquire the bus
      step(0,0,1,0,8'h00,8'hA5, 2'd1,0,8'h00,0,0,0,8'h00);
      step(0,0,1,0,8'h00,8'hA5, 2'd1,0,8'h00,0,0,0,8'h00);
      step(0,0,1,0,8'h00,8'hA5, 2'd2,1,8'h00,1,0,0,8'h00);
      // back-to-back writes
      step(0,0,1,1,8'h3C,8'hA5, 2'd2,1,8'h3C,1,0,0,8'h00);
      step(0,0,1,1,8'hC3,8'hA5, 2'd2,1,8'hC3,1,0,0,8'h00);
      // release with a write offered in the same cycle
      step(0,0,0,1,8'h55,8'hA5, 2'd3,0,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'hA5, 2'd3,0,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'hA5, 2'd0,0,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'h5A, 2'd0,0,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'h5A, 2'd0,0,8'hC3,0,1,1,8'h5A);
      // one-cycle dir_req pulse: full out-and-back
      step(0,0,1,0,8'h00,8'h5A, 2'd1,0,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'h5A, 2'd1,0,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'h5A, 2'd2,1,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'h5A, 2'd3,0,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'h5A, 2'd3,0,8'hC3,0,0,0,8'h00);
      step(0,0,0,0,8'h00,8'h5A, 2'd0,0,8'hC3,0,0,0,8'h00);
      // drive 8'hFF then reset while driving
      step(0,0,1,0,8'h00,8'h5A, 2'd1,0,8'hC3,0,0,0,8'h00);
      step(0,0,1,0,8'h00,8'h5A, 2'd1,0,8'hC3,0,0,0,8'h00);
      step(0,0,1,0,8'h00,8'h5A, 2'd2,1,8'hC3,1,0,0,8'h00);
      step(0,0,1,1,8'hFF,8'h5A, 2'd2,1,8'hFF,1,0,0,8'h00);
      step(0,1,1,0,8'h00,8'h5A, 2'd0,0,8'h00,0,0,1,8'h00);
      step(0,0,0,0,8'h00,8'h5A, 2'd0,0,8'h00,0,0,0,8'h00);

      // TURN_CYCLES=0 regression
      step(1,1,0,0,8'h00,8'h3C, 2'd0,0,8'h00,0,0,1,8'h00);
      step(1,0,0,0,8'h00,8'h3C, 2'd0,0,8'h00,0,0,0,8'h00);
      step(1,0,0,0,8'h00,8'h3C, 2'd0,0,8'h00,0,1,1,8'h3C);
      step(1,0,1,0,8'h00,8'h3C, 2'd2,1,8'h00,1,0,0,8'h00);
      step(1,0,1,1,8'h96,8'h3C, 2'd2,1,8'h96,1,0,0,8'h00);
      step(1,0,0,1,8'h69,8'h3C, 2'd0,0,8'h96,0,0,0,8'h00);
      step(1,0,0,0,8'h00,8'h3C, 2'd0,0,8'h96,0,0,0,8'h00);
      step(1,0,0,0,8'h00,8'h3C, 2'd0,0,8'h96,0,1,1,8'h3C);
      step(1,0,1,0,8'h00,8'h3C, 2'd2,1,8'h96,1,0,0,8'h00);
      step(1,0,0,0,8'h00,8'h3C, 2'd0,0,8'h96,0,0,0,8'h00);
      step(1,0,1,0,8'h00,8'h3C, 2'd2,1,8'h96,1,0,0,8'h00);
      step(1,0,1,1,8'hE7,8'h3C, 2'd2,1,8'hE7,1,0,0,8'h00);
      step(1,1,1,0,8'h00,8'h3C, 2'd0,0,8'h00,0,0,1,8'h00);

      repeat (2) @(posedge clk);
      #5;
      chk("queue_drained", row_no, 8'(q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
